spi_latch_reader: RTL and testbench

- SPI mode-0 master that reads the 24-bit hit-latch frame from the chamber FPGA's SPI slave port.
- Drives chip select and SCLK and shifts in MISO MSB-first. Presents each completed frame on a valid/ready output port.
- A frame starts on a software request or on a rising edge of the FPGA's asynchronous trigger line.
- Sits in the acquisition controller, between the FPGA link and the event buffer.

---
 rtl/spi_latch_reader.sv | 113 +++++++++++
 tb/tb_spi_latch_reader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_latch_reader.sv
// rtl/spi_latch_reader.sv - SPI mode-0 master reading the chamber FPGA hit-latch frame
// Frames start on a software or trigger request; results are held on a valid/ready slot.
module spi_latch_reader #(
  parameter int FRAME_BITS = 24,
  parameter int CLK_DIV    = 8,
  parameter int CS_SETUP   = 8,
  parameter int CS_HOLD    = 4,
  parameter int CS_GAP     = 8
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  trig_in,
  input  logic                  auto_en,
  output logic                  spi_cs,
  output logic                  spi_clk,
  input  logic                  spi_miso,
  output logic [FRAME_BITS-1:0] data,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  busy,
  output logic [7:0]            missed
);
  localparam int CNT_W = 16;
  localparam int BIT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]      cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shift;
  logic                  trig_s1, trig_s2, trig_prev;
  logic                  miso_s1, miso_s;
  logic                  req, slot_free, accept, sample, done;

  assign req       = start | (auto_en & trig_s2 & ~trig_prev);
  assign slot_free = ~data_valid | data_ready;
  assign accept    = req & slot_free & (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = SETUP;
      SETUP: if (cnt == CNT_W'(CS_SETUP - 1)) state_nxt = HIGH;
      HIGH: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          state_nxt = LOW;
          sample    = 1'b1;
        end
      end
      LOW: begin
        if (cnt == CNT_W'(CLK_DIV - 1))
          state_nxt = (bit_cnt < BIT_W'(FRAME_BITS)) ? HIGH : HOLD;
      end
      HOLD: begin
        if (cnt == CNT_W'(CS_HOLD - 1)) begin
          state_nxt = GAP;
          done      = 1'b1;
        end
      end
      GAP:     if (cnt == CNT_W'(CS_GAP - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SPI pins are registered from the next state so they never glitch
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      trig_s1    <= 1'b0;
      trig_s2    <= 1'b0;
      trig_prev  <= 1'b0;
      miso_s1    <= 1'b0;
      miso_s     <= 1'b0;
      spi_cs     <= 1'b1;
      spi_clk    <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      missed     <= '0;
    end else begin
      trig_s1   <= trig_in;
      trig_s2   <= trig_s1;
      trig_prev <= trig_s2;
      miso_s1   <= spi_miso;
      miso_s    <= miso_s1;
      state     <= state_nxt;
      cnt       <= (state_nxt != state) ? '0 : cnt + 1'b1;
      spi_cs    <= (state_nxt == IDLE) || (state_nxt == GAP);
      spi_clk   <= (state_nxt == HIGH);
      if (accept)
        bit_cnt <= '0;
      if (sample) begin
        shift   <= {shift[FRAME_BITS-2:0], miso_s};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (done) begin
        data       <= shift;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      if (req && !accept && missed != 8'hFF)
        missed <= missed + 8'd1;
    end
  end
endmodule

// File: tb/tb_spi_latch_reader.sv
// tb/tb_spi_latch_reader.sv - directed self-checking bench for spi_latch_reader
// Instance d0 uses defaults; d1 uses FRAME_BITS=8, CLK_DIV=4.
module tb_spi_latch_reader;
  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        rst;
  logic        start0, trig0, auto0, miso0, ready0;
  logic        cs0, sclk0, dv0, busy0;
  logic [23:0] data0;
  logic [7:0]  missed0;
  logic        start1, trig1, auto1, miso1, ready1;
  logic        cs1, sclk1, dv1, busy1;
  logic [7:0]  data1;
  logic [7:0]  missed1;

  int checks = 0;
  int errors = 0;

  logic [23:0] slv0, sr0;
  logic [7:0]  slv1, sr1;

  spi_latch_reader d0 (
    .sys_clk(sys_clk), .rst(rst), .start(start0), .trig_in(trig0), .auto_en(auto0),
    .spi_cs(cs0), .spi_clk(sclk0), .spi_miso(miso0), .data(data0), .data_valid(dv0),
    .data_ready(ready0), .busy(busy0), .missed(missed0)
  );

  spi_latch_reader #(.FRAME_BITS(8), .CLK_DIV(4)) d1 (
    .sys_clk(sys_clk), .rst(rst), .start(start1), .trig_in(trig1), .auto_en(auto1),
    .spi_cs(cs1), .spi_clk(sclk1), .spi_miso(miso1), .data(data1), .data_valid(dv1),
    .data_ready(ready1), .busy(busy1), .missed(missed1)
  );

  // Slave models: load on CS fall, present the next bit a few cycles after each SCLK rise
  always @(negedge cs0) sr0 = slv0;
  always @(posedge sclk0) begin
    repeat (3) @(posedge sys_clk);
    #1;
    miso0 = sr0[23];
    sr0 = {sr0[22:0], 1'b0};
  end
  always @(negedge cs1) sr1 = slv1;
  always @(posedge sclk1) begin
    @(posedge sys_clk);
    #1;
    miso1 = sr1[7];
    sr1 = {sr1[6:0], 1'b0};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge sys_clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic consume(input bit sel);
    if (sel) ready1 = 1'b1; else ready0 = 1'b1;
    @(negedge sys_clk);
    ready0 = 1'b0;
    ready1 = 1'b0;
  endtask

  task automatic measure(input bit sel, input int exp_low, input int exp_rises, input int exp_half);
    int   low_cyc, rises, run, hmin, hmax, lmin, lmax;
    logic pc, ck, dv_last;
    low_cyc = 0; rises = 0; run = 0; pc = 1'b0; dv_last = 1'b0;
    hmin = 1000; hmax = 0; lmin = 1000; lmax = 0;
    for (int n = 0; n < 20 && (sel ? cs1 : cs0) !== 1'b0; n++) @(negedge sys_clk);
    chk("cs_fall", sel ? cs1 : cs0, 1'b0);
    while ((sel ? cs1 : cs0) === 1'b0 && low_cyc < 2000) begin
      ck = sel ? sclk1 : sclk0;
      if (ck !== pc) begin
        if (pc) begin
          if (run < hmin) hmin = run;
          if (run > hmax) hmax = run;
        end else begin
          if (rises > 0) begin
            if (run < lmin) lmin = run;
            if (run > lmax) lmax = run;
          end
          rises++;
        end
        run = 0;
        pc = ck;
      end
      run++;
      low_cyc++;
      dv_last = sel ? dv1 : dv0;
      @(negedge sys_clk);
    end
    chk("cs_low_cycles", low_cyc, exp_low);
    chk("sclk_rises", rises, exp_rises);
    chk("sclk_high_min", hmin, exp_half);
    chk("sclk_high_max", hmax, exp_half);
    chk("sclk_low_min", lmin, exp_half);
    chk("sclk_low_max", lmax, exp_half);
    chk("sclk_low_at_cs_rise", sel ? sclk1 : sclk0, 1'b0);
    chk("dv_low_in_frame", dv_last, 1'b0);
    chk("dv_after_hold", sel ? dv1 : dv0, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog elapsed_ns=%0t limit_ns=2000000", $time);
    $fatal(1);
  end

  initial begin
    int   lows, lat, r, n, frames, hrun, gap_min;
    logic pc, pcs;
    rst = 1'b1;
    {start0, trig0, auto0, miso0, ready0} = '0;
    {start1, trig1, auto1, miso1, ready1} = '0;
    slv0 = '0; slv1 = '0;
    repeat (3) @(negedge sys_clk);
    chk("rst_cs", cs0, 1'b1);
    chk("rst_sclk", sclk0, 1'b0);
    chk("rst_data", data0, 24'h0);
    chk("rst_dv", dv0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_missed", missed0, 8'd0);
    rst = 1'b0;
    @(negedge sys_clk);

    slv0 = 24'hA5C3F0;
    pulse_start(0);
    measure(0, 396, 24, 8);
    chk("data_frame1", data0, 24'hA5C3F0);

    repeat (20) @(negedge sys_clk);
    lows = 0;
    for (int i = 0; i < 3; i++) begin
      pulse_start(0);
      repeat (5) begin
        if (cs0 === 1'b0) lows++;
        @(negedge sys_clk);
      end
    end
    chk("blocked_no_cs", lows, 0);
    chk("blocked_missed", missed0, 8'd3);
    chk("blocked_data_held", data0, 24'hA5C3F0);
    chk("blocked_dv_held", dv0, 1'b1);
    consume(0);
    chk("dv_cleared", dv0, 1'b0);
    slv0 = 24'h3C96E1;
    pulse_start(0);
    measure(0, 396, 24, 8);
    chk("data_frame2", data0, 24'h3C96E1);
    consume(0);

    repeat (20) @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);
    auto0 = 1'b1;
    slv0 = 24'h000001;
    #2 trig0 = 1'b1;
    lat = 0;
    while (cs0 === 1'b1 && lat < 10) begin
      @(negedge sys_clk);
      lat++;
    end
    chk("trig_latency_le3", lat <= 3, 1'b1);
    fork
      measure(0, 396, 24, 8);
      begin
        repeat (100) @(negedge sys_clk);
        trig0 = 1'b0;
        repeat (10) @(negedge sys_clk);
        trig0 = 1'b1;
      end
    join
    chk("trig_data", data0, 24'h000001);
    chk("trig_missed", missed0, 8'd1);
    consume(0);

    repeat (20) @(negedge sys_clk);
    auto0 = 1'b0;
    trig0 = 1'b0;
    repeat (5) @(negedge sys_clk);
    trig0 = 1'b1;
    lows = 0;
    repeat (20) begin
      if (cs0 === 1'b0) lows++;
      @(negedge sys_clk);
    end
    chk("auto_off_no_cs", lows, 0);
    chk("auto_off_missed", missed0, 8'd1);
    chk("auto_off_dv", dv0, 1'b0);

    slv0 = 24'hFFFFFF;
    pulse_start(0);
    r = 0; n = 0; pc = 1'b0;
    while (r < 10 && n < 1000) begin
      if (sclk0 === 1'b1 && pc === 1'b0) r++;
      pc = sclk0;
      @(negedge sys_clk);
      n++;
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_cs", cs0, 1'b1);
    chk("midrst_sclk", sclk0, 1'b0);
    chk("midrst_dv", dv0, 1'b0);
    chk("midrst_data", data0, 24'h0);
    chk("midrst_missed", missed0, 8'd0);
    @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);
    slv0 = 24'h5A5A5A;
    pulse_start(0);
    measure(0, 396, 24, 8);
    chk("post_rst_data", data0, 24'h5A5A5A);

    ready0 = 1'b1;
    frames = 0; hrun = 0; gap_min = 1000; pcs = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      start0 = (i % 4 == 0);
      @(negedge sys_clk);
      if (cs0 === 1'b1) begin
        hrun++;
      end else begin
        if (pcs === 1'b1) begin
          frames++;
          if (frames > 1 && hrun < gap_min) gap_min = hrun;
        end
        hrun = 0;
      end
      pcs = cs0;
    end
    start0 = 1'b0;
    chk("b2b_frames_ge2", frames >= 2, 1'b1);
    chk("b2b_gap_ge_cs_gap", gap_min >= 8, 1'b1);
    chk("b2b_missed_sat", missed0, 8'd255);
    n = 0;
    while (busy0 === 1'b1 && n < 600) begin
      @(negedge sys_clk);
      n++;
    end
    chk("b2b_idle", busy0, 1'b0);
    ready0 = 1'b0;

    slv1 = 8'hFF;
    pulse_start(1);
    measure(1, 76, 8, 4);
    chk("d1_data_ff", data1, 8'hFF);
    consume(1);
    repeat (12) @(negedge sys_clk);
    slv1 = 8'h00;
    pulse_start(1);
    measure(1, 76, 8, 4);
    chk("d1_data_00", data1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
